// File: rtl/ram_sdp_clr_if.sv
// Request/response bundle for ram_sdp_clr: write port, read port, clear request and status.
// master drives requests, slave (the RAM) returns registered read data, valid and busy.
interface ram_sdp_clr_if #(
  parameter int DATA_WIDTH    = 5,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     clr_req;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     busy;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with a self-zeroing clear engine; RAM_BYPASS_EN selects write-first on same-address collisions.
// Read latency 1 cycle; all requests are ignored while busy (clear owns the array for 2**ADDRESS_WIDTH cycles).
module ram_sdp_clr #(
  parameter int DATA_WIDTH    = 5,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_sdp_clr_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

`ifdef RAM_BYPASS_EN
  assign rd_word = (bus.wr_en && (bus.wr_addr == bus.rd_addr)) ? bus.wr_data : mem_q[bus.rd_addr];
`else
  assign rd_word = mem_q[bus.rd_addr];
`endif

  // The clear engine steals the write port; user requests only reach the array in READY.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = bus.wr_addr;
    mem_wdata  = bus.wr_data;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
      end
      ST_READY: begin
        mem_we = bus.wr_en;
        if (bus.rd_en) begin
          rd_data_d  = rd_word;
          rd_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Scoreboard bench for ram_sdp_clr: driver pushes expected reads, negedge monitor pops on rd_valid.
// Build with +define+RAM_BYPASS_EN to check the write-first variant.
module tb_ram_sdp_clr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_sdp_clr_if #(.DATA_WIDTH(5), .ADDRESS_WIDTH(5)) bif ();

  ram_sdp_clr #(.DATA_WIDTH(5), .ADDRESS_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc_cnt  = 0;
  logic [4:0]  exp_dat_q [$];
  int unsigned exp_cyc_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read, in data and in cycle.
  always @(negedge clk) begin
    if (rst_n && bif.rd_valid) begin
      if (exp_dat_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        logic [4:0]  ed;
        int unsigned ec;
        ed = exp_dat_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("rd_data", {27'd0, bif.rd_data}, {27'd0, ed});
        chk("rd_latency", cyc_cnt, ec);
      end
    end
  end

  task automatic zero_inputs();
    bif.clr_req = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_addr = '0;
    bif.wr_data = '0;
    bif.rd_en   = 1'b0;
    bif.rd_addr = '0;
  endtask

  // Called at a negedge; drives one cycle of requests and returns at the next negedge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [4:0] wd,
                     input logic re, input logic [4:0] ra, input logic [4:0] ed,
                     input logic clr);
    bif.wr_en   = we;
    bif.wr_addr = wa;
    bif.wr_data = wd;
    bif.rd_en   = re;
    bif.rd_addr = ra;
    bif.clr_req = clr;
    if (re) begin
      exp_dat_q.push_back(ed);
      exp_cyc_q.push_back(cyc_cnt + 1);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic count_busy(input string name, input bit junk);
    int n = 0;
    while (bif.busy && n < 200) begin
      n++;
      if (junk) begin
        bif.wr_en   = 1'b1;
        bif.wr_addr = 5'(n);
        bif.wr_data = 5'h1F;
        bif.rd_en   = 1'b1;
        bif.rd_addr = 5'(n);
        bif.clr_req = 1'b1;
      end
      @(negedge clk);
      if (junk && bif.busy) chk("rd_valid_in_clear", {31'd0, bif.rd_valid}, 32'd0);
    end
    zero_inputs();
    chk(name, n, 32);
  endtask

  task automatic fill();
    for (int a = 0; a < 32; a++) cyc(1'b1, 5'(a), 5'(a), 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  logic [4:0] exp_coll;

  initial begin
    zero_inputs();
    #1;
    chk("reset_busy", {31'd0, bif.busy}, 32'd1);
    chk("reset_rd_valid", {31'd0, bif.rd_valid}, 32'd0);
    chk("reset_rd_data", {27'd0, bif.rd_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("busy_after_reset", 1'b0);

    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0,  5'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd17, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 5'd0, 1'b0);

    cyc(1'b1, 5'd3, 5'h1A, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'h1A, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("idle_rd_valid", {31'd0, bif.rd_valid}, 32'd0);
    chk("idle_rd_data_hold", {27'd0, bif.rd_data}, 32'h1A);

`ifdef RAM_BYPASS_EN
    exp_coll = 5'h0F;
`else
    exp_coll = 5'h04;
`endif
    cyc(1'b1, 5'd7, 5'h04, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 5'd7, 5'h0F, 1'b1, 5'd7, exp_coll, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'h0F, 1'b0);

    cyc(1'b1, 5'd9, 5'h11, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 5'd2, 5'h1C, 1'b1, 5'd9, 5'h11, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 5'h1C, 1'b0);

    // Full clear with junk traffic; the read issued alongside clr_req is still served.
    fill();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd5, 1'b1);
    count_busy("busy_clr_req", 1'b1);
    for (int a = 0; a < 32; a++) cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'(a), 5'd0, 1'b0);

    // Reset in the middle of a clear.
    fill();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd5, 1'b1);
    repeat (9) @(negedge clk);
    chk("mid_clear_busy", {31'd0, bif.busy}, 32'd1);
    chk("mid_clear_rd_data_hold", {27'd0, bif.rd_data}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rd_data", {27'd0, bif.rd_data}, 32'd0);
    chk("async_reset_rd_valid", {31'd0, bif.rd_valid}, 32'd0);
    chk("async_reset_busy", {31'd0, bif.busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("busy_after_mid_reset", 1'b0);
    for (int a = 0; a < 32; a += 5) cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'(a), 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 5'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_dat_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised simple-dual-port synchronous RAM with independent write and read ports, registered read data with a valid strobe, and a hardware clear engine that zeroes every location after reset or on request. It replaces single-port lab RAMs wherever switch/button-driven or FSM-driven logic must write and read in the same cycle. It also serves any block that needs known-zero contents without an init file.

## Interface
- DATA_WIDTH, 5, bits per word
- ADDRESS_WIDTH, 5, address bits; depth = 2**ADDRESS_WIDTH words (locations 0 to 2**ADDRESS_WIDTH-1)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr_req  input  1  request full-memory clear (sampled in READY only)
- wr_en  input  1  write strobe
- wr_addr  input  ADDRESS_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- rd_en  input  1  read strobe
- rd_addr  input  ADDRESS_WIDTH  read address
- rd_data  output  DATA_WIDTH  registered read data
- rd_valid  output  1  high one cycle after an accepted read
- busy  output  1  high while clear engine owns the array

## Operation
- Two states: CLEAR, READY. Reset (rst_n=0) forces CLEAR, clear counter = 0, rd_data = 0, rd_valid = 0, busy = 1.
- CLEAR: each cycle writes 0 to location clr_cnt, increments clr_cnt; on the cycle writing location 2**ADDRESS_WIDTH-1, next state READY. Clear takes exactly 2**ADDRESS_WIDTH cycles. wr_en, rd_en, clr_req ignored; rd_valid = 0; rd_data holds.
- READY: busy = 0. wr_en=1 writes wr_data to wr_addr. rd_en=1 is accepted; rd_data loads array[rd_addr], rd_valid = 1 next cycle. rd_en=0 gives rd_valid = 0, rd_data holds last value.
- clr_req=1 in READY: next state CLEAR, clr_cnt = 0, busy = 1 next cycle. Any wr_en/rd_en in that same cycle are still performed.
- Simultaneous write and read to different addresses: both performed, independent.
- Same-address write and read in one cycle: result set by RAM_BYPASS_EN (see Configuration).
- rst_n asserted mid-clear or mid-read: immediate return to reset values; array contents not reset asynchronously, re-zeroed by the following CLEAR.
- Array contents are not reset by rst_n; only the clear engine or writes change them.

## Timing
- Write latency: data visible to a read issued the cycle after the write edge.
- Read latency: 1 cycle (rd_en at edge N, rd_data/rd_valid valid after edge N+1).
- busy falls at the edge that completes location 2**ADDRESS_WIDTH-1; first accepted access at that following edge.
- rst_n deassertion: first CLEAR write at first rising edge with rst_n=1.
- No combinational path from inputs to outputs.

## Configuration
- RAM_BYPASS_EN defined: same-address write+read in one cycle returns the new wr_data on rd_data (write-first).
- RAM_BYPASS_EN undefined: returns the previous stored word (read-first); pure inferred-RAM behaviour, no bypass mux.

## Test plan
- Release rst_n, count busy cycles -> busy high exactly 32 cycles (defaults); then reads of addresses 0, 17, 31 return 0 with rd_valid one cycle after rd_en.
- Write 5'h1A to addr 3, next cycle read addr 3 -> rd_data = 5'h1A, rd_valid = 1 for one cycle; rd_en low afterwards -> rd_valid 0, rd_data stays 5'h1A.
- Same cycle: write 5'h0F to addr 7 (old 5'h04), read addr 7 -> 5'h0F with RAM_BYPASS_EN, 5'h04 without.
- Fill addr 0..31 with addr value, pulse clr_req -> busy 32 cycles, wr_en/rd_en during clear ignored (rd_valid stays 0), afterwards all reads return 0.
- Assert rst_n low at clear cycle 10 for 2 cycles -> outputs return to reset values immediately; clear restarts from addr 0 and lasts full 32 cycles.
- Write addr 2 and read addr 9 (holding 5'h11) in one cycle -> rd_data = 5'h11; subsequent read addr 2 returns written value.
